// File: rtl/timer_pkg.sv
// Shared definitions for the two-mode timer: run-state encoding, mode
// constants and the mode-B preset step.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timerState_e;

    localparam logic MODE_A      = 1'b0;
    localparam logic MODE_B      = 1'b1;
    localparam int   PRESET_STEP = 30;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to the 1 s boundary: counts 0..TICK_DIV-1
// while enabled, holds when disabled, and flags the terminal value.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic wrap
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (clear) begin
            presc <= '0;
        end else if (enable) begin
            presc <= (presc == LAST) ? '0 : presc + 1'b1;
        end
    end

    // Raw terminal flag; the owner decides in which states it means a tick.
    assign wrap = (presc == LAST);

endmodule

// File: rtl/timer_run_ctrl.sv
// Run controller for the two-mode timer (count-up stopwatch / count-down preset).
// Optional build macro TIMER_ALARM_EN adds a blinking alarm output in DONE.
module timer_run_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_sel,
    input  logic [2:0]       time_control,
    input  logic             start_stop,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             tick,
    output logic             running,
`ifdef TIMER_ALARM_EN
    output logic             done,
    output logic             alarm
`else
    output logic             done
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    timerState_e      state, nextState;
    logic [CNT_W-1:0] nextCount;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] loadVal;
    logic             modeQ;
    logic [2:0]       ctrlQ;
    logic             changeDet;
    logic             wrap;
    logic             prescEnable;
    logic             prescClear;

    assign preset    = (CNT_W'(time_control) + CNT_W'(1)) * CNT_W'(PRESET_STEP);
    assign loadVal   = (mode_sel == MODE_B) ? preset : '0;
    assign changeDet = (mode_sel != modeQ) || ((time_control != ctrlQ) && (mode_sel == MODE_B));

`ifdef TIMER_ALARM_EN
    assign prescEnable = (state == RUN) || (state == DONE);
    assign prescClear  = (state == IDLE);
`else
    assign prescEnable = (state == RUN);
    assign prescClear  = (state == IDLE) || (state == DONE);
`endif

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) uPresc (
        .clk    (clk),
        .rst    (rst),
        .enable (prescEnable),
        .clear  (prescClear),
        .wrap   (wrap)
    );

    assign tick = (state == RUN) && wrap;

    // A terminal tick overrides a simultaneous pause request.
    always_comb begin
        nextState = state;
        nextCount = count;
        if (clear || changeDet) begin
            nextState = IDLE;
            nextCount = loadVal;
        end else begin
            unique case (state)
                IDLE: begin
                    nextCount = loadVal;
                    if (start_stop) nextState = RUN;
                end
                RUN: begin
                    if (start_stop) nextState = PAUSE;
                    if (tick) begin
                        if (mode_sel == MODE_A) begin
                            if (count != CNT_MAX) nextCount = count + 1'b1;
                            if (count >= CNT_MAX - CNT_W'(1)) nextState = DONE;
                        end else begin
                            if (count != '0) nextCount = count - 1'b1;
                            if (count <= CNT_W'(1)) nextState = DONE;
                        end
                    end
                end
                PAUSE: begin
                    if (start_stop) nextState = RUN;
                end
                DONE: begin
                    if (start_stop) begin
                        nextState = IDLE;
                        nextCount = loadVal;
                    end
                end
                default: nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            count   <= '0;
            modeQ   <= 1'b0;
            ctrlQ   <= 3'd0;
            running <= 1'b0;
            done    <= 1'b0;
`ifdef TIMER_ALARM_EN
            alarm   <= 1'b0;
`endif
        end else begin
            state   <= nextState;
            count   <= nextCount;
            modeQ   <= mode_sel;
            ctrlQ   <= time_control;
            running <= (nextState == RUN);
            done    <= (nextState == DONE);
`ifdef TIMER_ALARM_EN
            alarm   <= ((state == DONE) && (nextState == DONE)) ? (alarm ^ wrap) : 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_timer_run_ctrl.sv
// Directed bench for timer_run_ctrl with TICK_DIV = 4, CNT_W = 12.
// Inputs change 1 time unit after the rising edge; outputs are read there too.
module tb_timer_run_ctrl;

    logic        clk;
    logic        rst;
    logic        mode_sel;
    logic [2:0]  time_control;
    logic        start_stop;
    logic        clear;
    logic [11:0] count;
    logic        tick;
    logic        running;
    logic        done;
`ifdef TIMER_ALARM_EN
    logic        alarm;
`endif

    int checks;
    int errors;

    timer_run_ctrl #(
        .TICK_DIV (4),
        .CNT_W    (12)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode_sel     (mode_sel),
        .time_control (time_control),
        .start_stop   (start_stop),
        .clear        (clear),
        .count        (count),
        .tick         (tick),
        .running      (running),
`ifdef TIMER_ALARM_EN
        .done         (done),
        .alarm        (alarm)
`else
        .done         (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulseStart;
        start_stop = 1'b1;
        step(1);
        start_stop = 1'b0;
    endtask

    task automatic pulseClear;
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        mode_sel = 1'b0;
        time_control = 3'd0;
        start_stop = 1'b0;
        clear = 1'b0;
        step(2);
        checks++;
        if (count !== 12'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++;
        if ({tick, running, done} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: tick/run/done got %b want 000", {tick, running, done});
        end
        rst = 1'b1;
        step(2);
        checks++;
        if ({running, done, count} !== {2'b00, 12'd0}) begin
            errors++; $display("FAIL reset_idle: run=%b done=%b count=%0d want 0 0 0", running, done, count);
        end
    endtask

    task automatic test_mode_a;
        int ticks;
        ticks = 0;
        pulseStart();
        checks++;
        if (running !== 1'b1 || count !== 12'd0) begin
            errors++; $display("FAIL a_start: run=%b count=%0d want 1 0", running, count);
        end
        for (int i = 1; i <= 12; i++) begin
            if (tick === 1'b1) ticks++;
            step(1);
            checks++;
            if (count !== 12'(i / 4)) begin
                errors++; $display("FAIL a_count[%0d]: got %0d want %0d", i, count, i / 4);
            end
        end
        checks++;
        if (ticks != 3) begin errors++; $display("FAIL a_ticks: got %0d want 3", ticks); end
        pulseClear();
        checks++;
        if (running !== 1'b0 || count !== 12'd0) begin
            errors++; $display("FAIL a_clear: run=%b count=%0d want 0 0", running, count);
        end
    endtask

    task automatic test_mode_b;
        mode_sel = 1'b1;
        time_control = 3'd1;
        step(2);
        checks++;
        if (count !== 12'd60) begin errors++; $display("FAIL b_load: got %0d want 60", count); end
        pulseStart();
        for (int i = 1; i <= 239; i++) begin
            step(1);
            checks++;
            if (count !== 12'(60 - i / 4)) begin
                errors++; $display("FAIL b_count[%0d]: got %0d want %0d", i, count, 60 - i / 4);
            end
        end
        checks++;
        if (done !== 1'b0 || running !== 1'b1) begin
            errors++; $display("FAIL b_predone: done=%b run=%b want 0 1", done, running);
        end
        step(1);
        checks++;
        if (count !== 12'd0 || done !== 1'b1 || running !== 1'b0) begin
            errors++; $display("FAIL b_done: count=%0d done=%b run=%b want 0 1 0", count, done, running);
        end
        step(6);
        checks++;
        if (count !== 12'd0 || done !== 1'b1 || tick !== 1'b0) begin
            errors++; $display("FAIL b_hold: count=%0d done=%b tick=%b want 0 1 0", count, done, tick);
        end
        pulseStart();
        checks++;
        if (done !== 1'b0 || count !== 12'd60) begin
            errors++; $display("FAIL b_restart: done=%b count=%0d want 0 60", done, count);
        end
    endtask

    task automatic test_pause;
        mode_sel = 1'b0;
        step(2);
        checks++;
        if (count !== 12'd0) begin errors++; $display("FAIL p_load: got %0d want 0", count); end
        pulseStart();
        step(5);
        start_stop = 1'b1;
        step(1);
        start_stop = 1'b0;
        checks++;
        if (running !== 1'b0 || count !== 12'd1) begin
            errors++; $display("FAIL p_enter: run=%b count=%0d want 0 1", running, count);
        end
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++;
            if (count !== 12'd1 || tick !== 1'b0) begin
                errors++; $display("FAIL p_frozen[%0d]: count=%0d tick=%b want 1 0", i, count, tick);
            end
        end
        pulseStart();
        checks++;
        if (running !== 1'b1 || tick !== 1'b0) begin
            errors++; $display("FAIL p_resume: run=%b tick=%b want 1 0", running, tick);
        end
        step(1);
        checks++;
        if (tick !== 1'b1 || count !== 12'd1) begin
            errors++; $display("FAIL p_tick: tick=%b count=%0d want 1 1", tick, count);
        end
        step(1);
        checks++;
        if (count !== 12'd2) begin errors++; $display("FAIL p_after: got %0d want 2", count); end
        pulseClear();
    endtask

    task automatic test_tick_and_pause;
        pulseStart();
        step(3);
        checks++;
        if (tick !== 1'b1) begin errors++; $display("FAIL tp_tick: got %b want 1", tick); end
        start_stop = 1'b1;
        step(1);
        start_stop = 1'b0;
        checks++;
        if (count !== 12'd1 || running !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL tp_pause: count=%0d run=%b done=%b want 1 0 0", count, running, done);
        end
        step(3);
        checks++;
        if (count !== 12'd1) begin errors++; $display("FAIL tp_hold: got %0d want 1", count); end
        pulseClear();
    endtask

    task automatic test_change;
        mode_sel = 1'b1;
        time_control = 3'd1;
        step(2);
        pulseStart();
        step(40);
        checks++;
        if (count !== 12'd50 || running !== 1'b1) begin
            errors++; $display("FAIL c_run: count=%0d run=%b want 50 1", count, running);
        end
        time_control = 3'd0;
        step(1);
        checks++;
        if (running !== 1'b0) begin errors++; $display("FAIL c_idle: run=%b want 0", running); end
        step(1);
        checks++;
        if (count !== 12'd30) begin errors++; $display("FAIL c_reload: got %0d want 30", count); end
        mode_sel = 1'b0;
        step(2);
        checks++;
        if (count !== 12'd0) begin errors++; $display("FAIL c_modea: got %0d want 0", count); end
        pulseStart();
        step(6);
        time_control = 3'd3;
        step(1);
        checks++;
        if (running !== 1'b1) begin errors++; $display("FAIL c_ignore: run=%b want 1", running); end
        step(1);
        checks++;
        if (count !== 12'd2) begin errors++; $display("FAIL c_keep: got %0d want 2", count); end
        pulseClear();
    endtask

    task automatic test_clear_and_reset;
        pulseStart();
        step(2);
        start_stop = 1'b1;
        clear = 1'b1;
        step(1);
        start_stop = 1'b0;
        clear = 1'b0;
        checks++;
        if (running !== 1'b0 || count !== 12'd0 || done !== 1'b0) begin
            errors++; $display("FAIL sc_idle: run=%b count=%0d done=%b want 0 0 0", running, count, done);
        end
        pulseStart();
        step(5);
        checks++;
        if (count !== 12'd1 || running !== 1'b1) begin
            errors++; $display("FAIL rr_run: count=%0d run=%b want 1 1", count, running);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({count, tick, running, done} !== {12'd0, 3'b000}) begin
            errors++; $display("FAIL rr_async: count=%0d tick=%b run=%b done=%b want all 0", count, tick, running, done);
        end
        step(1);
        rst = 1'b1;
        step(1);
    endtask

    task automatic test_saturate;
        pulseStart();
        step(16379);
        checks++;
        if (count !== 12'd4094 || done !== 1'b0) begin
            errors++; $display("FAIL s_pre: count=%0d done=%b want 4094 0", count, done);
        end
        step(1);
        checks++;
        if (count !== 12'd4095 || done !== 1'b1 || running !== 1'b0) begin
            errors++; $display("FAIL s_done: count=%0d done=%b run=%b want 4095 1 0", count, done, running);
        end
        step(8);
        checks++;
        if (count !== 12'd4095) begin errors++; $display("FAIL s_hold: got %0d want 4095", count); end
        pulseClear();
    endtask

`ifdef TIMER_ALARM_EN
    task automatic test_alarm;
        mode_sel = 1'b1;
        time_control = 3'd0;
        step(2);
        pulseStart();
        step(120);
        checks++;
        if (done !== 1'b1 || alarm !== 1'b0) begin
            errors++; $display("FAIL al_done: done=%b alarm=%b want 1 0", done, alarm);
        end
        step(3);
        checks++;
        if (alarm !== 1'b0) begin errors++; $display("FAIL al_pre: got %b want 0", alarm); end
        step(1);
        checks++;
        if (alarm !== 1'b1) begin errors++; $display("FAIL al_on: got %b want 1", alarm); end
        step(4);
        checks++;
        if (alarm !== 1'b0) begin errors++; $display("FAIL al_off: got %b want 0", alarm); end
        step(4);
        checks++;
        if (alarm !== 1'b1) begin errors++; $display("FAIL al_on2: got %b want 1", alarm); end
        pulseStart();
        checks++;
        if (alarm !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL al_exit: alarm=%b done=%b want 0 0", alarm, done);
        end
        mode_sel = 1'b0;
        step(2);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mode_a();
        test_mode_b();
        test_pause();
        test_tick_and_pause();
        test_change();
        test_clear_and_reset();
        test_saturate();
`ifdef TIMER_ALARM_EN
        test_alarm();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
